// File: rtl/lru_fill_reader_pkg.sv
// Shared types and constants for the cache backend fill path.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2
    } fill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Ceiling log2; clogb2(1) = 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (64'(value) > (64'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lru_fill_reader_if.sv
// Valid/ready stream bundle between the cache backend and the fill reader.
interface lru_fill_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;

    modport master(output tvalid, output tdata, input tready);
    modport slave(input tvalid, input tdata, output tready);
endinterface

// File: rtl/lru_fill_tag_buf.sv
// One-entry tag holding register; accepts only when empty.
module lru_fill_tag_buf #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/lru_fill_reader.sv
// Miss-fill engine: turns line tags into single AXI4 INCR read bursts and
// forwards the returned beats onto the backend data stream in order.
module lru_fill_reader
    import cache_pkg::*;
#(
    parameter int unsigned TAGS_WIDTH     = 48,
    parameter int unsigned CACHE_SIZE     = 512,
    parameter int unsigned DATA_PORT_SIZE = 512,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID         = 0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    lru_fill_reader_if.slave          addr_stream,
    lru_fill_reader_if.master         data_stream,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arid,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_PORT_SIZE-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    output logic                      rd_err,
    output logic [31:0]               fill_count
);

    localparam int unsigned BEATS = CACHE_SIZE / DATA_PORT_SIZE;
    localparam logic [8:0] LAST_BEAT = 9'(BEATS - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_BYTES = AXI_ADDR_WIDTH'(CACHE_SIZE / 8);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_AR   = 2'(AR);
    localparam logic [1:0] S_DATA = 2'(DATA);

    if (CACHE_SIZE % DATA_PORT_SIZE != 0) begin : g_bad_ratio
        $error("CACHE_SIZE must be a multiple of DATA_PORT_SIZE");
    end
    if (BEATS > 256 || BEATS < 1) begin : g_bad_beats
        $error("burst length must be 1..256 beats");
    end
    if (DATA_PORT_SIZE < 8 || (DATA_PORT_SIZE & (DATA_PORT_SIZE - 1)) != 0) begin : g_bad_port
        $error("DATA_PORT_SIZE must be a power of two >= 8");
    end

    logic [1:0]                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [8:0]                beat_cnt_q, beat_cnt_d;
    logic                      rd_err_q, rd_err_d;
    logic [31:0]               fill_count_q, fill_count_d;

    logic                  pend_valid, pend_ready, pend_pop;
    logic [TAGS_WIDTH-1:0] pend_tag, tag_sel;
    logic                  load_tag, in_data, r_hs, beat_err;

    // Outside IDLE every accepted tag is parked; in IDLE an empty buffer lets
    // the tag bypass straight into the address register.
    lru_fill_tag_buf #(
        .WIDTH(TAGS_WIDTH)
    ) u_tag_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (addr_stream.tvalid && (state_q != S_IDLE)),
        .in_ready (pend_ready),
        .in_data  (addr_stream.tdata),
        .out_valid(pend_valid),
        .out_ready(pend_pop),
        .out_data (pend_tag)
    );

    assign addr_stream.tready = pend_ready;
    assign pend_pop           = (state_q == S_IDLE);

    assign in_data            = (state_q == S_DATA);
    assign data_stream.tvalid = in_data && m_axi_rvalid;
    assign data_stream.tdata  = m_axi_rdata;
    assign m_axi_rready       = in_data && data_stream.tready;
    assign r_hs               = in_data && m_axi_rvalid && data_stream.tready;

    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'(clogb2(DATA_PORT_SIZE / 8));
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arid    = 4'(AXI_ID);
    assign rd_err        = rd_err_q;
    assign fill_count    = fill_count_q;

    assign beat_err = (m_axi_rresp != AXI_RESP_OKAY) ||
                      (m_axi_rlast && (beat_cnt_q != LAST_BEAT)) ||
                      (!m_axi_rlast && (beat_cnt_q == LAST_BEAT));

    always_comb begin
        state_d      = state_q;
        load_tag     = 1'b0;
        tag_sel      = pend_tag;
        beat_cnt_d   = beat_cnt_q;
        rd_err_d     = rd_err_q;
        fill_count_d = fill_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_valid) begin
                    load_tag = 1'b1;
                    state_d  = S_AR;
                end else if (addr_stream.tvalid) begin
                    load_tag = 1'b1;
                    tag_sel  = addr_stream.tdata;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    beat_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                // Only rlast ends the burst; count mismatches are just flagged.
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (beat_err) rd_err_d = 1'b1;
                    if (m_axi_rlast) begin
                        fill_count_d = fill_count_q + 32'd1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        araddr_d = load_tag ? BASE_ADDR + AXI_ADDR_WIDTH'(tag_sel) * LINE_BYTES : araddr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            araddr_q     <= '0;
            beat_cnt_q   <= '0;
            rd_err_q     <= 1'b0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_err_q     <= rd_err_d;
            fill_count_q <= fill_count_d;
        end
    end

endmodule
